// File: rtl/instr_fetch_if.sv
// Instruction memory read channel: req/ready request phase, rvalid response.
interface instr_fetch_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 32
);
    logic                   mem_req;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic                   mem_ready;
    logic                   mem_rvalid;
    logic [INSTR_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns PC and IR, runs one instruction read per fetch_start.
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH     = 16,
    parameter int INSTR_WIDTH    = 32,
    parameter int RESET_PC       = 0,
    parameter int PC_STEP        = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fetch_start,
    input  logic                   pc_load,
    input  logic [ADDR_WIDTH-1:0]  pc_load_value,
    instr_fetch_if.master          mem,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [5:0]             opcode,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   fetch_done,
    output logic                   busy,
    output logic                   fault
);

    localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] STEP   = ADDR_WIDTH'(PC_STEP);
    localparam logic [7:0]            TO     = 8'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_FAULT
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [INSTR_WIDTH-1:0]  instr_q;
    logic                    req_q;
    logic                    done_q;
    logic                    busy_q;
    logic                    fault_q;
    logic [7:0]              cnt;
    logic                    pend;
    logic [ADDR_WIDTH-1:0]   pend_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc_q     <= RST_PC;
            addr_q   <= RST_PC;
            instr_q  <= '0;
            req_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
            cnt      <= '0;
            pend     <= 1'b0;
            pend_val <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (pc_load) begin
                        pc_q <= pc_load_value;
                    end
                    if (fetch_start) begin
                        state  <= S_REQ;
                        req_q  <= 1'b1;
                        busy_q <= 1'b1;
                        addr_q <= pc_load ? pc_load_value : pc_q;
                    end
                end
                S_REQ: begin
                    if (pc_load) begin
                        pend     <= 1'b1;
                        pend_val <= pc_load_value;
                    end
                    if (mem.mem_ready) begin
                        state <= S_WAIT;
                        req_q <= 1'b0;
                        cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (pc_load) begin
                        pend     <= 1'b1;
                        pend_val <= pc_load_value;
                    end
                    if (mem.mem_rvalid) begin
                        state   <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        instr_q <= mem.mem_rdata;
                        pend    <= 1'b0;
                        // A load arriving with the response is the newest one.
                        if (pc_load) begin
                            pc_q <= pc_load_value;
                        end else if (pend) begin
                            pc_q <= pend_val;
                        end else begin
                            pc_q <= addr_q + STEP;
                        end
                    end else if (cnt + 8'd1 == TO) begin
                        state   <= S_FAULT;
                        busy_q  <= 1'b0;
                        fault_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    if (pc_load) begin
                        pc_q <= pc_load_value;
                    end
                end
                S_FAULT: begin
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    fault_q <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;
    assign instr        = instr_q;
    assign opcode       = instr_q[INSTR_WIDTH-1 -: 6];
    assign pc           = pc_q;
    assign fetch_done   = done_q;
    assign busy         = busy_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: stimulus queues expected addresses/responses, monitor checks.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fetch_start = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_value = '0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [15:0] pc;
    logic        fetch_done;
    logic        busy;
    logic        fault;

    instr_fetch_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(32)) bus ();

    instruction_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_start   (fetch_start),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .mem           (bus),
        .instr         (instr),
        .opcode        (opcode),
        .pc            (pc),
        .fetch_done    (fetch_done),
        .busy          (busy),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  op;
        logic [15:0] npc;
    } resp_t;

    resp_t       exp_q[$];
    logic [15:0] addr_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: request addresses, request stability, fetch results, pulse width
    logic        prev_hold = 1'b0;
    logic        prev_done = 1'b0;
    logic [15:0] prev_addr = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_hold) begin
                check("mem_req_held", bus.mem_req, 1);
                check("mem_addr_stable", bus.mem_addr, prev_addr);
            end
            if (bus.mem_req && bus.mem_ready) begin
                if (addr_q.size() == 0) begin
                    check("unexpected_request", 1, 0);
                end else begin
                    check("mem_addr", bus.mem_addr, addr_q.pop_front());
                end
            end
            if (fetch_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_fetch_done", 1, 0);
                end else begin
                    resp_t r;
                    r = exp_q.pop_front();
                    check("instr", instr, r.data);
                    check("opcode", opcode, r.op);
                    check("pc_after_fetch", pc, r.npc);
                end
            end
            if (prev_done) check("fetch_done_pulse", fetch_done, 0);
            prev_hold = bus.mem_req && !bus.mem_ready;
            prev_addr = bus.mem_addr;
            prev_done = fetch_done;
        end
    end

    // Called at posedge+1 with the unit in IDLE; returns the same way.
    task automatic fetch(input logic [15:0] a, input logic [31:0] d,
                         input logic [5:0] op, input logic [15:0] npc,
                         input int rdy_wait, input int rv_wait,
                         input bit wl, input logic [15:0] wv,
                         input bit sl, input logic [15:0] sv);
        resp_t r;
        r.data = d;
        r.op   = op;
        r.npc  = npc;
        addr_q.push_back(a);
        exp_q.push_back(r);
        fetch_start   = 1'b1;
        pc_load       = sl;
        pc_load_value = sv;
        @(posedge clk); #1;
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        check("busy_req", busy, 1);
        for (int i = 0; i < rdy_wait; i++) begin
            bus.mem_ready  = 1'b0;
            bus.mem_rvalid = (i == 0);
            bus.mem_rdata  = 32'hBAD0_BAD0;
            @(posedge clk); #1;
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_ready  = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        check("mem_req_drop", bus.mem_req, 0);
        for (int i = 0; i < rv_wait; i++) begin
            pc_load       = wl && (i < 2);
            pc_load_value = (i == 0) ? 16'h0077 : wv;
            @(posedge clk); #1;
            pc_load = 1'b0;
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = d;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        check("fetch_done_latency", fetch_done, 1);
        check("busy_done", busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic idle_load(input logic [15:0] v);
        pc_load       = 1'b1;
        pc_load_value = v;
        @(posedge clk); #1;
        pc_load = 1'b0;
        check("pc_idle_load", pc, v);
    endtask

    initial begin
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", pc, 16'h0000);
        check("rst_instr", instr, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_addr", bus.mem_addr, 16'h0000);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_fetch_done", fetch_done, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // basic fetch, best-case latency
        fetch(16'h0000, 32'hFC00_0001, 6'h3F, 16'h0001, 0, 0, 0, 0, 0, 0);
        // backpressure with stray rvalid in REQ
        fetch(16'h0001, 32'h1234_5678, 6'h04, 16'h0002, 5, 1, 0, 0, 0, 0);
        // PC load in IDLE then fetch from it
        idle_load(16'h0040);
        fetch(16'h0040, 32'h8000_0000, 6'h20, 16'h0041, 0, 0, 0, 0, 0, 0);
        // two loads during WAIT, last one wins
        fetch(16'h0041, 32'h0400_0000, 6'h01, 16'h0100, 0, 3, 1, 16'h0100, 0, 0);
        // wrap at the top of the address space
        idle_load(16'hFFFF);
        fetch(16'hFFFF, 32'hDEAD_BEEF, 6'h37, 16'h0000, 1, 0, 0, 0, 0, 0);
        // fetch_start and pc_load in the same cycle
        fetch(16'h0010, 32'h0C00_0000, 6'h03, 16'h0011, 0, 0, 0, 0, 1, 16'h0010);

        // async reset while WAITing
        addr_q.push_back(16'h0011);
        fetch_start = 1'b1;
        @(posedge clk); #1;
        fetch_start   = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        check("busy_wait", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_pc", pc, 16'h0000);
        check("async_rst_instr", instr, 0);
        check("async_rst_mem_req", bus.mem_req, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // timeout to fault
        addr_q.push_back(16'h0000);
        fetch_start = 1'b1;
        @(posedge clk); #1;
        fetch_start   = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        repeat (250) @(posedge clk);
        #1;
        check("no_early_fault", fault, 0);
        check("busy_long_wait", busy, 1);
        begin
            int k = 0;
            while (!fault && k < 20) begin
                @(posedge clk); #1;
                k++;
            end
        end
        check("fault_set", fault, 1);
        check("fault_mem_req", bus.mem_req, 0);
        check("fault_busy", busy, 0);
        fetch_start   = 1'b1;
        pc_load       = 1'b1;
        pc_load_value = 16'h1234;
        @(posedge clk); #1;
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        @(posedge clk); #1;
        check("fault_sticky", fault, 1);
        check("fault_ignores_start", bus.mem_req, 0);
        check("fault_ignores_load", pc, 16'h0000);
        pc_load_value = 16'h0000;
        #2 rst_n = 1'b0;
        #1;
        check("rst_clears_fault", fault, 0);
        check("rst_fault_pc", pc, 16'h0000);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // recovery after reset
        fetch(16'h0000, 32'hFC00_0001, 6'h3F, 16'h0001, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("addr_queue_empty", addr_q.size(), 0);
        check("resp_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
